// File: rtl/collatz_pkg.sv
// Shared types and constants for the collatz kernel sweep driver.
// Holds the state encoding, the default data width and the timeout step marker.
package collatz_pkg;

  localparam int DEFAULT_W = 32;

  // Step count reported for an invocation that was abandoned on timeout.
  localparam logic [DEFAULT_W-1:0] TIMEOUT_STEPS = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KRST,
    S_KRUN,
    S_EMIT,
    S_DONE
  } state_t;

  // Timer width able to hold the limit itself; stays at least 1 bit when the timeout is disabled.
  function automatic int timer_width(input int limit);
    return (limit <= 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/collatz_call_ctrl.sv
// Runs one kernel invocation: reset pulse, start, then wait for finish or timeout.
// A go pulse launches it; done is a single-cycle pulse in the cycle the result is captured.
module collatz_call_ctrl
  import collatz_pkg::*;
#(
  parameter int KRST_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic kern_finish,
  output logic krst_last,
  output logic done,
  output logic timed_out,
  output logic kern_rst_n,
  output logic kern_start
);

  localparam int CW = (KRST_CYCLES <= 1) ? 1 : $clog2(KRST_CYCLES + 1);
  localparam int TW = timer_width(TIMEOUT_CYCLES);

  state_t          phase, phase_n;
  logic [CW-1:0]   krst_cnt;
  logic [TW-1:0]   timer, timer_inc;
  logic            limit_hit;

  always_comb begin
    timer_inc  = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);
    limit_hit  = (TIMEOUT_CYCLES != 0) && (timer_inc == TW'(TIMEOUT_CYCLES));
    krst_last  = (phase == S_KRST) && (krst_cnt == CW'(KRST_CYCLES - 1));
    // A finish seen in the same cycle as the limit takes precedence.
    done       = (phase == S_KRUN) && (kern_finish || limit_hit);
    timed_out  = (phase == S_KRUN) && !kern_finish && limit_hit;
    kern_rst_n = (phase == S_KRUN);
    kern_start = (phase == S_KRUN);
  end

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_n = phase;
    unique case (phase)
      S_IDLE:  if (go)        phase_n = S_KRST;
      S_KRST:  if (krst_last) phase_n = S_KRUN;
      S_KRUN:  if (done)      phase_n = S_IDLE;
      default:                phase_n = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) phase <= S_IDLE;
    else     phase <= phase_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      krst_cnt <= '0;
      timer    <= '0;
    end else begin
      krst_cnt <= (phase == S_KRST) ? krst_cnt + CW'(1) : '0;
      timer    <= (phase == S_KRUN) ? timer_inc : '0;
    end
  end

endmodule

// File: rtl/collatz_sweep.sv
// Sweep driver for the collatz kernel: one invocation per n, per-n result stream,
// and a summary of the longest trajectory and the number of timed-out invocations.
module collatz_sweep
  import collatz_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int KRST_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_lo,
  input  logic [W-1:0] cmd_count,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_n,
  output logic [W-1:0] res_steps,
  output logic         res_timeout,
  output logic         sum_valid,
  output logic [W-1:0] sum_max_n,
  output logic [W-1:0] sum_max_steps,
  output logic [W-1:0] sum_timeouts,
  output logic         kern_rst_n,
  output logic         kern_start,
  output logic [W-1:0] kern_n,
  input  logic         kern_finish,
  input  logic [W-1:0] kern_ret
);

  localparam logic [W-1:0] STEPS_ON_TIMEOUT = '1;

  state_t        state, state_n;
  logic [W-1:0]  cur_n, remaining;
  logic          cmd_fire, res_fire, last_n, go;
  logic          call_krst_last, call_done, call_timed_out;

  collatz_call_ctrl #(
    .KRST_CYCLES    (KRST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_call (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .kern_finish (kern_finish),
    .krst_last   (call_krst_last),
    .done        (call_done),
    .timed_out   (call_timed_out),
    .kern_rst_n  (kern_rst_n),
    .kern_start  (kern_start)
  );

  always_comb begin
    cmd_ready = (state == S_IDLE);
    res_valid = (state == S_EMIT);
    cmd_fire  = cmd_ready && cmd_valid;
    res_fire  = res_valid && res_ready;
    last_n    = (remaining == W'(1));
    go        = (cmd_fire && (cmd_count != '0)) || (res_fire && !last_n);
    kern_n    = cur_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (cmd_fire)       state_n = (cmd_count != '0) ? S_KRST : S_DONE;
      S_KRST: if (call_krst_last) state_n = S_KRUN;
      S_KRUN: if (call_done)      state_n = S_EMIT;
      S_EMIT: if (res_fire)       state_n = last_n ? S_DONE : S_KRST;
      S_DONE:                     state_n = S_IDLE;
      default:                    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_n         <= '0;
      remaining     <= '0;
      res_n         <= '0;
      res_steps     <= '0;
      res_timeout   <= 1'b0;
      sum_valid     <= 1'b0;
      sum_max_n     <= '0;
      sum_max_steps <= '0;
      sum_timeouts  <= '0;
    end else begin
      if (cmd_fire) begin
        cur_n         <= cmd_lo;
        remaining     <= cmd_count;
        sum_valid     <= 1'b0;
        sum_max_n     <= '0;
        sum_max_steps <= '0;
        sum_timeouts  <= '0;
      end
      if (call_done) begin
        res_n       <= cur_n;
        res_steps   <= call_timed_out ? STEPS_ON_TIMEOUT : kern_ret;
        res_timeout <= call_timed_out;
      end
      if (res_fire) begin
        // Strict compare keeps the earliest n on ties; timeouts never compete.
        if (!res_timeout && (res_steps > sum_max_steps)) begin
          sum_max_n     <= res_n;
          sum_max_steps <= res_steps;
        end
        sum_timeouts <= sum_timeouts + W'(res_timeout);
        cur_n        <= cur_n + W'(1);
        remaining    <= remaining - W'(1);
      end
      if (state_n == S_DONE) sum_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collatz_sweep.sv
// Self-checking bench for collatz_sweep with a behavioural kernel stand-in.
// Directed table vectors, a few hand-written corner sequences, then randomized sweeps.
module tb_collatz_sweep;
  import collatz_pkg::*;

  localparam int W    = 32;
  localparam int KRST = 2;
  localparam int TMO  = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_lo, cmd_count;
  logic         res_valid, res_ready;
  logic [W-1:0] res_n, res_steps;
  logic         res_timeout;
  logic         sum_valid;
  logic [W-1:0] sum_max_n, sum_max_steps, sum_timeouts;
  logic         kern_rst_n, kern_start;
  logic [W-1:0] kern_n;
  logic         kern_finish;
  logic [W-1:0] kern_ret;

  always #5 clk = ~clk;

  collatz_sweep #(.W(W), .KRST_CYCLES(KRST), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_lo        (cmd_lo),
    .cmd_count     (cmd_count),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_n         (res_n),
    .res_steps     (res_steps),
    .res_timeout   (res_timeout),
    .sum_valid     (sum_valid),
    .sum_max_n     (sum_max_n),
    .sum_max_steps (sum_max_steps),
    .sum_timeouts  (sum_timeouts),
    .kern_rst_n    (kern_rst_n),
    .kern_start    (kern_start),
    .kern_n        (kern_n),
    .kern_finish   (kern_finish),
    .kern_ret      (kern_ret)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Collatz trajectory length computed with wide arithmetic.
  function automatic logic [W-1:0] ref_steps(input logic [W-1:0] n);
    longint unsigned x = longint'(n);
    int s = 0;
    while (x > 1 && s < 100000) begin
      x = (x % 2 == 1) ? 3 * x + 1 : x / 2;
      s++;
    end
    return W'(s);
  endfunction

  // Kernel stand-in: random latency after reset release, sticky finish, or hangs forever.
  bit           hang = 1'b0;
  logic         k_finish = 1'b0;
  logic [W-1:0] k_ret = '0;
  int           k_cnt = 0;
  int           k_lat = 0;

  assign kern_finish = k_finish;
  assign kern_ret    = k_ret;

  always @(posedge clk) begin
    if (!kern_rst_n) begin
      k_finish <= 1'b0;
      k_cnt    <= 0;
      k_lat    <= $urandom_range(0, 8);
    end else if (kern_start && !k_finish && !hang) begin
      if (k_cnt >= k_lat) begin
        k_finish <= 1'b1;
        k_ret    <= ref_steps(kern_n);
      end else begin
        k_cnt <= k_cnt + 1;
      end
    end
  end

  // Length of each contiguous kern_start burst (cycles spent running the kernel).
  int run_len = 0;
  int run_q[$];
  always @(negedge clk) begin
    if (rst) run_len <= 0;
    else if (kern_start) run_len <= run_len + 1;
    else if (run_len > 0) begin
      run_q.push_back(run_len);
      run_len <= 0;
    end
  end

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] cnt;
    bit           hang;
    bit           stall;
    bit           has_exp;
    logic [W-1:0] e_max_n;
    logic [W-1:0] e_max_steps;
    logic [W-1:0] e_tmo;
  } vec_t;

  task automatic run_sweep(input vec_t v);
    logic [W-1:0] exp_n[$], exp_s[$];
    bit           exp_t[$];
    logic [W-1:0] got_n[$], got_s[$];
    bit           got_t[$];
    logic [W-1:0] n, s, m_n, m_s, m_t, hold_n, hold_s;
    int cyc;
    bit stalled;

    m_n = '0; m_s = '0; m_t = '0;
    for (int i = 0; i < int'(v.cnt); i++) begin
      n = v.lo + W'(i);
      s = v.hang ? TIMEOUT_STEPS : ref_steps(n);
      exp_n.push_back(n);
      exp_s.push_back(s);
      exp_t.push_back(v.hang);
      if (v.hang) m_t++;
      else if (s > m_s) begin
        m_s = s;
        m_n = n;
      end
    end

    hang = v.hang;
    run_q.delete();
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_lo    = v.lo;
    cmd_count = v.cnt;
    cmd_valid = 1'b1;
    res_ready = 1'b0;
    @(negedge clk);
    cyc = 0;
    stalled = 0;
    while (!sum_valid && cyc < 3000) begin
      // Commands offered mid-sweep must be ignored.
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_lo    = $urandom;
      cmd_count = $urandom_range(1, 9);
      if (res_valid && v.stall && !stalled) begin
        hold_n = res_n;
        hold_s = res_steps;
        res_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", res_valid, 1);
          check("stall_n", res_n, hold_n);
          check("stall_steps", res_steps, hold_s);
          check("stall_krst", kern_rst_n, 0);
          check("stall_kstart", kern_start, 0);
        end
        stalled = 1;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      if (res_valid && res_ready) begin
        got_n.push_back(res_n);
        got_s.push_back(res_steps);
        got_t.push_back(res_timeout);
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;

    check("sum_valid_seen", sum_valid, 1);
    if (v.cnt == 0) check("cnt0_latency_ok", cyc <= 1, 1);
    check("res_count", got_n.size(), exp_n.size());
    for (int i = 0; i < got_n.size() && i < exp_n.size(); i++) begin
      check("res_n", got_n[i], exp_n[i]);
      check("res_steps", got_s[i], exp_s[i]);
      check("res_timeout", got_t[i], exp_t[i]);
    end
    check("sum_max_n", sum_max_n, m_n);
    check("sum_max_steps", sum_max_steps, m_s);
    check("sum_timeouts", sum_timeouts, m_t);
    if (v.has_exp) begin
      check("tbl_max_n", sum_max_n, v.e_max_n);
      check("tbl_max_steps", sum_max_steps, v.e_max_steps);
      check("tbl_timeouts", sum_timeouts, v.e_tmo);
    end
    if (v.hang) begin
      check("tmo_runs", run_q.size(), v.cnt);
      foreach (run_q[i]) check("tmo_run_len", run_q[i], TMO);
    end
    @(negedge clk);
    check("ready_after_done", cmd_ready, 1);
    check("sum_held", sum_valid, 1);
  endtask

  vec_t tbl[7];
  vec_t rv;
  int   wait_cyc;
  bit   saw_res;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_lo = '0; cmd_count = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_kern_rst_n", kern_rst_n, 0);
    check("rst_kern_start", kern_start, 0);
    check("rst_kern_n", kern_n, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_steps", res_steps, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum_max_n", sum_max_n, 0);
    check("rst_sum_timeouts", sum_timeouts, 0);
    rst = 1'b0;

    //          lo             cnt hang stall exp max_n max_s  tmo
    tbl[0] = '{32'd1,          3,  0,   0,    1,  3,    7,     0};
    tbl[1] = '{32'd12,         2,  0,   0,    1,  12,   9,     0};
    tbl[2] = '{32'd27,         1,  0,   0,    1,  27,   111,   0};
    tbl[3] = '{32'd5,          0,  0,   0,    1,  0,    0,     0};
    tbl[4] = '{32'd5,          2,  0,   1,    1,  6,    8,     0};
    tbl[5] = '{32'd100,        2,  1,   0,    1,  0,    0,     2};
    tbl[6] = '{32'hFFFF_FFFF,  2,  1,   1,    1,  0,    0,     2};
    for (int i = 0; i < 7; i++) run_sweep(tbl[i]);

    // Reset in the middle of a running invocation.
    hang = 1'b1;
    @(negedge clk);
    cmd_lo = 32'd27; cmd_count = 32'd3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_cyc = 0;
    while (!kern_start && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("reached_krun", kern_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_kern_rst_n", kern_rst_n, 0);
    check("midrst_kern_start", kern_start, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_sum_valid", sum_valid, 0);
    saw_res = 0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid || sum_valid || kern_start) saw_res = 1;
    end
    check("midrst_quiet", saw_res, 0);

    for (int i = 0; i < 6; i++) begin
      rv.lo          = $urandom_range(1, 3000);
      rv.cnt         = $urandom_range(1, 4);
      rv.hang        = ($urandom_range(0, 4) == 0);
      rv.stall       = ($urandom_range(0, 1) == 1);
      rv.has_exp     = 0;
      rv.e_max_n     = '0;
      rv.e_max_steps = '0;
      rv.e_tmo       = '0;
      run_sweep(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
